core_run_ctrl: RTL and testbench

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

---
 rtl/core_run_ctrl.sv | 140 ++++++++++++++
 tb/tb_core_run_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// Load/run sequencer for a soft core: streams a program into BRAM port B,
// releases the core, and captures its performance counters on halt or timeout.
module core_run_ctrl #(
    parameter logic [31:0] HALT_ADDR = 32'h0000_FFFC,
    parameter int unsigned MAX_WORDS = 4096,
    parameter logic [27:0] TIMEOUT   = 28'h0FF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [31:0] host_data,
    input  logic        host_last,
    output logic        load_sel,
    output logic [3:0]  load_we,
    output logic [31:0] load_addr,
    output logic [31:0] load_data,
    output logic        core_rst_n,
    input  logic [3:0]  mem_we_obs,
    input  logic [31:0] mem_addr_obs,
    input  logic [31:0] mem_wdata_obs,
    input  logic [27:0] clk_cycles_in,
    input  logic [12:0] retired_in,
    input  logic [12:0] preds_in,
    input  logic [12:0] correct_in,
    output logic [27:0] clk_cycles_snap,
    output logic [12:0] retired_snap,
    output logic [12:0] preds_snap,
    output logic [12:0] correct_snap,
    output logic [31:0] exit_code,
    output logic        done,
    output logic        timeout,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Wide enough to hold MAX_WORDS itself (up to 16384) after the final handshake.
    localparam int IDX_W = 15;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_WORDS - 1);

    state_t           cur, nxt;
    logic [IDX_W-1:0] idx;
    logic [27:0]      run_cnt;
    logic             hs, halt_hit, tmo_hit;

    assign state = cur;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        nxt        = cur;
        host_ready = 1'b0;
        load_sel   = 1'b0;
        load_we    = 4'h0;
        load_addr  = 32'h0;
        load_data  = 32'h0;
        hs         = 1'b0;
        halt_hit   = 1'b0;
        tmo_hit    = 1'b0;
        case (cur)
            S_IDLE, S_DONE: begin
                if (start) nxt = S_LOAD;
            end
            S_LOAD: begin
                host_ready = 1'b1;
                load_sel   = 1'b1;
                hs         = host_valid;
                if (hs) begin
                    load_we   = 4'hF;
                    load_addr = {{(30-IDX_W){1'b0}}, idx, 2'b00};
                    load_data = host_data;
                    if (host_last || idx == LAST_IDX) nxt = S_RUN;
                end
            end
            S_RUN: begin
                halt_hit = (mem_we_obs != 4'h0) && (mem_addr_obs == HALT_ADDR);
                tmo_hit  = (run_cnt == TIMEOUT - 28'd1);
                if (halt_hit || tmo_hit) nxt = S_DONE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_IDLE;
        else        cur <= nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rst_n      <= 1'b0;
            idx             <= '0;
            run_cnt         <= '0;
            done            <= 1'b0;
            timeout         <= 1'b0;
            exit_code       <= '0;
            clk_cycles_snap <= '0;
            retired_snap    <= '0;
            preds_snap      <= '0;
            correct_snap    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            core_rst_n <= (nxt == S_RUN);
            case (cur)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx     <= '0;
                        done    <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                S_LOAD: begin
                    run_cnt <= '0;
                    if (hs) idx <= idx + 1'b1;
                end
                S_RUN: begin
                    if (halt_hit || tmo_hit) begin
                        clk_cycles_snap <= clk_cycles_in;
                        retired_snap    <= retired_in;
                        preds_snap      <= preds_in;
                        correct_snap    <= correct_in;
                        exit_code       <= halt_hit ? mem_wdata_obs : 32'h0;
                        done            <= 1'b1;
                        timeout         <= !halt_hit;
                    end else begin
                        run_cnt <= run_cnt + 28'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Randomized self-checking bench for core_run_ctrl; expectations come from a
// word-count / run-cycle model of the load and run phases.
module tb_core_run_ctrl;

    localparam int          MW   = 4;
    localparam int          TO   = 16;
    localparam logic [31:0] HALT = 32'h0000_FFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, host_valid, host_ready, host_last;
    logic [31:0] host_data;
    logic        load_sel, core_rst_n, done, timeout;
    logic [3:0]  load_we, mem_we_obs;
    logic [31:0] load_addr, load_data, mem_addr_obs, mem_wdata_obs, exit_code;
    logic [27:0] clk_cycles_in, clk_cycles_snap;
    logic [12:0] retired_in, preds_in, correct_in, retired_snap, preds_snap, correct_snap;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    // Model of the captured results.
    logic [27:0] m_cc;
    logic [12:0] m_ret, m_prd, m_cor;
    logic [31:0] m_exit;

    always #5 clk = ~clk;

    core_run_ctrl #(.HALT_ADDR(HALT), .MAX_WORDS(MW), .TIMEOUT(28'(TO))) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data), .host_last(host_last),
        .load_sel(load_sel), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .core_rst_n(core_rst_n),
        .mem_we_obs(mem_we_obs), .mem_addr_obs(mem_addr_obs), .mem_wdata_obs(mem_wdata_obs),
        .clk_cycles_in(clk_cycles_in), .retired_in(retired_in), .preds_in(preds_in), .correct_in(correct_in),
        .clk_cycles_snap(clk_cycles_snap), .retired_snap(retired_snap), .preds_snap(preds_snap),
        .correct_snap(correct_snap), .exit_code(exit_code),
        .done(done), .timeout(timeout), .state(state)
    );

    task automatic clear_model();
        m_cc = '0; m_ret = '0; m_prd = '0; m_cor = '0; m_exit = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (state !== 2'd0 || core_rst_n !== 1'b0 || load_sel !== 1'b0 || host_ready !== 1'b0 ||
            load_we !== 4'h0 || done !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL %s_ctrl: state=%0d crst=%b sel=%b ready=%b we=%h done=%b to=%b required all zero",
                     tag, state, core_rst_n, load_sel, host_ready, load_we, done, timeout);
        end
        total++;
        if (exit_code !== 32'h0 || clk_cycles_snap !== 28'h0 || retired_snap !== 13'h0 ||
            preds_snap !== 13'h0 || correct_snap !== 13'h0) begin
            bad++;
            $display("FAIL %s_snaps: exit=%h cc=%h ret=%h prd=%h cor=%h required all zero",
                     tag, exit_code, clk_cycles_snap, retired_snap, preds_snap, correct_snap);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; host_valid = 0; host_data = '0; host_last = 0;
        mem_we_obs = '0; mem_addr_obs = '0; mem_wdata_obs = '0;
        clk_cycles_in = '0; retired_in = '0; preds_in = '0; correct_in = '0;
        clear_model();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 3; i++) begin
            host_valid = 1'b1; host_data = $urandom; host_last = 1'($urandom);
            #1;
            total++;
            if (load_we !== 4'h0 || host_ready !== 1'b0 || state !== 2'd0) begin
                bad++;
                $display("FAIL idle_ignore: we=%h ready=%b state=%0d required we=0 ready=0 state=0",
                         load_we, host_ready, state);
            end
            @(negedge clk);
        end
        host_valid = 1'b0; host_last = 1'b0;
    endtask

    // Called at a negedge while IDLE or DONE; returns at negedge+1 in LOAD.
    task automatic do_start();
        start = 1'b1; host_valid = 1'b1; host_data = $urandom;
        #1;
        total++;
        if (load_we !== 4'h0 || host_ready !== 1'b0) begin
            bad++;
            $display("FAIL start_cycle_ignore: we=%h ready=%b required we=0 ready=0", load_we, host_ready);
        end
        @(negedge clk);
        start = 1'b0; host_valid = 1'b0;
        #1;
        total++;
        if (state !== 2'd1 || done !== 1'b0 || timeout !== 1'b0 || core_rst_n !== 1'b0 ||
            exit_code !== m_exit || clk_cycles_snap !== m_cc || retired_snap !== m_ret ||
            preds_snap !== m_prd || correct_snap !== m_cor) begin
            bad++;
            $display("FAIL start_enter_load: state=%0d done=%b to=%b crst=%b exit=%h cc=%h required state=1 done=0 to=0 crst=0 exit=%h cc=%h",
                     state, done, timeout, core_rst_n, exit_code, clk_cycles_snap, m_exit, m_cc);
        end
    endtask

    // Streams words until host_last (at word last_at) or MW words; gap idle cycles between words.
    task automatic load_program(input int last_at, input int gap, input bit directed);
        int sent;
        bit fin;
        logic [31:0] exp_addr;
        sent = 0; fin = 0;
        while (!fin) begin
            if (sent > 0) begin
                for (int g = 0; g < gap; g++) begin
                    host_valid = 1'b0; start = 1'($urandom); host_data = $urandom;
                    #1;
                    total++;
                    if (load_we !== 4'h0 || host_ready !== 1'b1 || load_sel !== 1'b1 || core_rst_n !== 1'b0) begin
                        bad++;
                        $display("FAIL load_idle: we=%h ready=%b sel=%b crst=%b required we=0 ready=1 sel=1 crst=0",
                                 load_we, host_ready, load_sel, core_rst_n);
                    end
                    @(negedge clk);
                end
            end
            host_valid = 1'b1; start = 1'($urandom);
            host_data  = directed ? 32'(32'h11 * (sent + 1)) : $urandom;
            host_last  = (sent == last_at);
            exp_addr   = 32'(sent * 4);
            #1;
            total++;
            if (load_we !== 4'hF || load_addr !== exp_addr || load_data !== host_data) begin
                bad++;
                $display("FAIL load_write: we=%h addr=%h data=%h required we=f addr=%h data=%h",
                         load_we, load_addr, load_data, exp_addr, host_data);
            end
            @(negedge clk);
            sent++;
            fin = host_last || (sent == MW);
        end
        // Host keeps offering data: nothing more may be accepted.
        start = 1'b0; host_last = 1'b0; host_valid = 1'b1;
        #1;
        total++;
        if (state !== 2'd2 || core_rst_n !== 1'b1 || host_ready !== 1'b0 || load_sel !== 1'b0 || load_we !== 4'h0) begin
            bad++;
            $display("FAIL load_to_run: state=%0d crst=%b ready=%b sel=%b we=%h required state=2 crst=1 ready=0 sel=0 we=0",
                     state, core_rst_n, host_ready, load_sel, load_we);
        end
    endtask

    // Starts in the first RUN cycle. halt_at<0 means no halt; the run then ends by timeout.
    task automatic run_phase(input int halt_at, input bit fixed);
        int end_k;
        end_k = (halt_at >= 0) ? halt_at : TO - 1;
        for (int k = 0; k <= end_k; k++) begin
            start = 1'($urandom); host_valid = 1'($urandom); host_data = $urandom; host_last = 1'($urandom);
            clk_cycles_in = 28'($urandom); retired_in = 13'($urandom);
            preds_in = 13'($urandom); correct_in = 13'($urandom);
            mem_wdata_obs = $urandom;
            if (k == halt_at) begin
                mem_we_obs = fixed ? 4'hF : 4'($urandom_range(15, 1));
                mem_addr_obs = HALT;
                if (fixed) begin
                    mem_wdata_obs = 32'h2A; clk_cycles_in = 28'd100;
                    retired_in = 13'd50; preds_in = 13'd7; correct_in = 13'd5;
                end
            end else begin
                case ($urandom % 3)
                    0:       begin mem_we_obs = 4'h0; mem_addr_obs = HALT; end
                    1:       begin mem_we_obs = 4'($urandom_range(15, 1)); mem_addr_obs = HALT - 32'd4; end
                    default: begin mem_we_obs = 4'h0; mem_addr_obs = $urandom; end
                endcase
            end
            if (k == end_k) begin
                m_cc = clk_cycles_in; m_ret = retired_in; m_prd = preds_in; m_cor = correct_in;
                m_exit = (halt_at >= 0) ? mem_wdata_obs : 32'h0;
            end
            #1;
            total++;
            if (state !== 2'd2 || core_rst_n !== 1'b1 || done !== 1'b0 || load_we !== 4'h0 || host_ready !== 1'b0) begin
                bad++;
                $display("FAIL run_cycle%0d: state=%0d crst=%b done=%b we=%h ready=%b required state=2 crst=1 done=0 we=0 ready=0",
                         k, state, core_rst_n, done, load_we, host_ready);
            end
            @(negedge clk);
        end
        start = 1'b0; host_valid = 1'b0; mem_we_obs = 4'h0;
        #1;
        total++;
        if (state !== 2'd3 || done !== 1'b1 || timeout !== (halt_at < 0) || core_rst_n !== 1'b0) begin
            bad++;
            $display("FAIL run_end: state=%0d done=%b to=%b crst=%b required state=3 done=1 to=%b crst=0",
                     state, done, timeout, core_rst_n, halt_at < 0);
        end
        total++;
        if (exit_code !== m_exit || clk_cycles_snap !== m_cc || retired_snap !== m_ret ||
            preds_snap !== m_prd || correct_snap !== m_cor) begin
            bad++;
            $display("FAIL run_capture: exit=%h cc=%0d ret=%0d prd=%0d cor=%0d required exit=%h cc=%0d ret=%0d prd=%0d cor=%0d",
                     exit_code, clk_cycles_snap, retired_snap, preds_snap, correct_snap,
                     m_exit, m_cc, m_ret, m_prd, m_cor);
        end
    endtask

    task automatic test_basic_load_halt();
        do_start();
        load_program(2, 0, 1'b1);
        run_phase(5, 1'b1);
    endtask

    task automatic test_gaps();
        do_start();
        load_program(3, 2, 1'b0);
        run_phase(3, 1'b0);
    endtask

    task automatic test_max_words_timeout();
        do_start();
        load_program(-1, 0, 1'b0);
        run_phase(-1, 1'b0);
    endtask

    task automatic test_halt_at_timeout();
        do_start();
        load_program(0, 1, 1'b0);
        run_phase(TO - 1, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            do_start();
            load_program(($urandom % 4 == 0) ? -1 : int'($urandom_range(MW - 1, 0)),
                         int'($urandom_range(2, 0)), 1'b0);
            run_phase(($urandom % 3 == 0) ? -1 : int'($urandom_range(TO - 1, 0)), 1'b0);
        end
    endtask

    task automatic test_reset_mid_load();
        do_start();
        host_valid = 1'b1; host_data = $urandom; host_last = 1'b0;
        @(negedge clk);
        host_data = $urandom;
        #1 rst_n = 1'b0;
        #1;
        clear_model();
        check_reset_outputs("reset_mid_load");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (load_we !== 4'h0 || state !== 2'd0) begin
                bad++;
                $display("FAIL post_reset_idle: we=%h state=%0d required we=0 state=0", load_we, state);
            end
            @(negedge clk);
        end
        host_valid = 1'b0;
        do_start();
        load_program(1, 0, 1'b0);
        run_phase(2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_basic_load_halt();
        test_gaps();
        test_max_words_timeout();
        test_halt_at_timeout();
        test_random();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
